// File: rtl/data_memory_responder.sv
// Word-organised data RAM answering the core's mem_valid/mem_ready handshake.
// One request at a time, WAIT_CYCLES wait states, one-cycle registered response.
module data_memory_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [32:0] BASE_EXT = {1'b0, BASE};
    localparam logic [32:0] LIMIT    = {1'b0, BASE} + (33'(DEPTH) << 2);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          ready_q;
    logic [31:0]   rdata_q;
    logic          error_q;

    logic [31:0]   ram [DEPTH];

    logic [31:0]   look_addr_d;
    logic [32:0]   look_ext_d;
    logic          in_range_d;
    logic [AW-1:0] look_idx_d;
    logic [31:0]   rd_word_d;

    // Address used for the array: the live bus while idle (zero-wait case enters
    // RESP on the capture edge), the latched request otherwise.
    always_comb begin
        look_addr_d = addr_q;
        if (state_q == S_IDLE) begin
            look_addr_d = mem_addr;
        end else begin
            look_addr_d = addr_q;
        end
        look_ext_d = {1'b0, look_addr_d};
        in_range_d = (look_ext_d >= BASE_EXT) && (look_ext_d < LIMIT);
        look_idx_d = look_addr_d[AW+1:2];
        rd_word_d  = ram[look_idx_d];
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        if (WAIT_CYCLES == 32'd0) begin
                            state_q <= S_RESP;
                            ready_q <= 1'b1;
                            error_q <= !in_range_d;
                            rdata_q <= in_range_d ? rd_word_d : 32'd0;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        error_q <= !in_range_d;
                        rdata_q <= in_range_d ? rd_word_d : 32'd0;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Store commit on the edge leaving RESP; reset on that edge discards it.
    always_ff @(posedge clk) begin
        if (rst && (state_q == S_RESP) && (wstrb_q != 4'd0) && in_range_d) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram[look_idx_d][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign mem_error = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized phase against a word-array reference model.
module tb_data_memory_responder;

    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    data_memory_responder #(
        .DEPTH(DEPTH),
        .BASE(32'h0000_0000),
        .WAIT_CYCLES(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected response from the reference model, then apply any store to it.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic er);
        int idx;
        er = (a >= 32'(DEPTH * 4));
        idx = int'(a[31:2] % 30'(DEPTH));
        rd = er ? 32'd0 : mdl[idx];
        if (!er) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // One full transaction starting in IDLE; returns one cycle after RESP.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic er);
        int k;
        bit got;
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (mem_ready) got = 1'b1;
        end
        chk("ready_seen", 32'(got), 32'd1);
        chk("latency", 32'(k), 32'(W + 1));
        rd = mem_rdata;
        er = mem_error;
        @(posedge clk);
        #1;
        chk("pulse_width", 32'(mem_ready), 32'd0);
        chk("idle_rdata", mem_rdata, 32'd0);
        chk("idle_error", 32'(mem_error), 32'd0);
        mem_valid = 1'b0;
    endtask

    task automatic run_and_check(input string nm, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
        logic [31:0] rd, erd;
        logic er, ere;
        model(a, d, s, erd, ere);
        do_req(a, d, s, rd, er);
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_error"}, 32'(er), 32'(ere));
    endtask

    initial begin
        vec_t vecs[11];
        logic [31:0] rd;
        logic er;
        int pulses[$];
        int k;

        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;

        // Reset held with a request present: no response.
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_addr = 32'h10;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_ready", 32'(mem_ready), 32'd0);
            chk("rst_rdata", mem_rdata, 32'd0);
            chk("rst_error", 32'(mem_error), 32'd0);
        end
        mem_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Known contents for the words the bench touches.
        for (int i = 0; i < 64; i++) begin
            do_req(32'(i * 4), 32'd0, 4'hF, rd, er);
        end
        do_req(32'hFFC, 32'd0, 4'hF, rd, er);

        vecs[0]  = '{32'h10,       32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{32'h10,       32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{32'h20,       32'h1122_3344, 4'h5, 32'h0,         1'b0};
        vecs[3]  = '{32'h20,       32'h0,         4'h0, 32'h0022_0044, 1'b0};
        vecs[4]  = '{32'h1000,     32'hAAAA_AAAA, 4'hF, 32'h0,         1'b1};
        vecs[5]  = '{32'hFFFF_FFFC, 32'h0,        4'h0, 32'h0,         1'b1};
        vecs[6]  = '{32'h0,        32'h0,         4'h0, 32'h0,         1'b0};
        vecs[7]  = '{32'h13,       32'h1234_5678, 4'hA, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{32'h10,       32'h0,         4'h0, 32'h12AD_56EF, 1'b0};
        vecs[9]  = '{32'hFFC,      32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
        vecs[10] = '{32'hFFC,      32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};

        foreach (vecs[i]) begin
            logic [31:0] mrd;
            logic mer;
            model(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, mrd, mer);
            do_req(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // Request held across two service periods: one pulse per W+2 cycles.
        mem_valid = 1'b1;
        mem_addr = 32'h10;
        mem_wstrb = 4'h0;
        for (int e = 1; e <= 2 * (W + 2); e++) begin
            @(posedge clk);
            #1;
            if (mem_ready) pulses.push_back(e);
        end
        mem_valid = 1'b0;
        chk("held_pulses", 32'(pulses.size()), 32'd2);
        if (pulses.size() == 2) begin
            chk("held_first", 32'(pulses[0]), 32'(W + 1));
            chk("held_second", 32'(pulses[1]), 32'(2 * W + 3));
        end

        // Reset while waiting: no response, store discarded.
        mem_valid = 1'b1;
        mem_addr = 32'h40;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_wait_ready", 32'(mem_ready), 32'd0);
        rst = 1'b1;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) k++;
        end
        chk("abort_wait_no_resp", 32'(k), 32'd0);
        run_and_check("abort_wait_read", 32'h40, 32'd0, 4'h0);

        // Reset on the commit edge: store discarded.
        mem_valid = 1'b1;
        mem_addr = 32'h44;
        mem_wdata = 32'h5A5A_5A5A;
        mem_wstrb = 4'hF;
        k = 0;
        while (!mem_ready && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("abort_resp_seen", 32'(mem_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_valid = 1'b0;
        chk("abort_resp_ready", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1;
        run_and_check("abort_resp_read", 32'h44, 32'd0, 4'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [3:0] s;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7) a = {22'd0, 8'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            else if (sel == 7) a = 32'hFFC;
            else a = $urandom | 32'h0000_1000;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_and_check("rand", a, $urandom, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
